// File: rtl/proc_pkg.sv
// proc_pkg
//   Shared definitions for the 9-bit processor: opcode values, control-step
//   state encoding and the IR field positions (III[8:6] XXX[5:3] YYY[2:0]).
//   Imported by the control unit and the datapath.
package proc_pkg;

    // Opcodes carried in IR[III_HI:III_LO]; 100..111 are reserved (NOP)
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // IR field bit positions
    localparam int unsigned III_HI = 8;
    localparam int unsigned III_LO = 6;
    localparam int unsigned XXX_HI = 5;
    localparam int unsigned XXX_LO = 3;
    localparam int unsigned YYY_HI = 2;
    localparam int unsigned YYY_LO = 0;

    // Instruction time steps, 2-bit binary; every code is a legal state
    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// dec3to8
//   3-bit binary to one-hot decoder used for the X and Y register fields.
// Ports
//   sel     in   3   register index
//   onehot  out  N   one-hot register select (bit sel set)
module dec3to8 #(
    parameter int unsigned N = 8
) (
    input  logic [2:0]   sel,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm
//   Multi-cycle control unit for the 9-bit processor datapath. Holds the
//   instruction register and steps each instruction through T0..T3, driving
//   the bus-source selects and the register/A/G/IR load enables.
// Ports
//   Clock   in   1       rising-edge clock
//   Reset   in   1       synchronous, active-high; forces all outputs except IR to 0
//   Run     in   1       start request, sampled only in T0
//   DIN     in   DATA_W  instruction word in T0, immediate operand in T1 (mvi)
//   IR      out  DATA_W  instruction register
//   IRin    out  1       IR load strobe
//   Rout    out  NREGS   one-hot register bus-source select
//   Gout    out  1       G drives the bus
//   DINout  out  1       DIN drives the bus
//   Rin     out  NREGS   one-hot register write enable
//   Ain     out  1       A load enable
//   Gin     out  1       G load enable
//   AddSub  out  1       ALU op: 0 = A+bus, 1 = A-bus
//   Done    out  1       last cycle of the instruction
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned NREGS  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] IR,
    output logic              IRin,
    output logic [NREGS-1:0]  Rout,
    output logic              Gout,
    output logic              DINout,
    output logic [NREGS-1:0]  Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);

    state_t           state;
    state_t           state_next;
    logic [2:0]       opcode;
    logic [2:0]       x_sel;
    logic [2:0]       y_sel;
    logic [NREGS-1:0] x_onehot;
    logic [NREGS-1:0] y_onehot;

    assign opcode = IR[III_HI:III_LO];
    assign x_sel  = IR[XXX_HI:XXX_LO];
    assign y_sel  = IR[YYY_HI:YYY_LO];

    dec3to8 #(.N(NREGS)) u_dec_x (
        .sel    (x_sel),
        .onehot (x_onehot)
    );

    dec3to8 #(.N(NREGS)) u_dec_y (
        .sel    (y_sel),
        .onehot (y_onehot)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            IR    <= '0;
        end else begin
            state <= state_next;
            if (IRin) begin
                IR <= DIN;
            end
        end
    end

    always_comb begin
        state_next = state;
        IRin       = 1'b0;
        Rout       = '0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        Rin        = '0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;

        case (state)
            T0: begin
                if (Run) begin
                    IRin       = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout       = y_onehot;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_MVI: begin
                        DINout     = 1'b1;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout       = x_onehot;
                        Ain        = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        // reserved opcodes complete immediately with no enables
                        Done       = 1'b1;
                        state_next = T0;
                    end
                endcase
            end
            T2: begin
                Rout       = y_onehot;
                Gin        = 1'b1;
                AddSub     = opcode[0];
                state_next = T3;
            end
            T3: begin
                Gout       = 1'b1;
                Rin        = x_onehot;
                Done       = 1'b1;
                state_next = T0;
            end
            default: state_next = T0;
        endcase

        // Reset masks every control output so an interrupted add/sub can
        // never reach its write-back step.
        if (Reset) begin
            IRin   = 1'b0;
            Rout   = '0;
            Gout   = 1'b0;
            DINout = 1'b0;
            Rin    = '0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            AddSub = 1'b0;
            Done   = 1'b0;
        end
    end

endmodule
